// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the tagged stream arbiter and its round-robin picker.
// Pure declarations; no logic, latency or backpressure of its own.
package stream_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  // Width of an index into n items, never zero so single-item instances still get a port.
  function automatic int src_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
// Purely combinational (0 cycles); no backpressure, any_req qualifies gnt.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = src_bits(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         any_req
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt     = W'((int'(ptr) + k) % N);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tagged_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_SOURCES streams, tagging each element with a per-packet serial.
// 1-cycle accept-to-output latency; granted source sees ready only when the output slot is empty or draining.
module tagged_stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 8,
  parameter int  SERIAL_WIDTH = 32,
  parameter int  NUM_SOURCES  = 4,
  localparam int ELEMENT_BITS = $clog2(NUM_ELEMENTS),
  localparam int SRC_BITS     = src_bits(NUM_SOURCES)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic  [NUM_SOURCES-1:0]                       in_vld,
  output logic  [NUM_SOURCES-1:0]                       in_rdy,
  input  data_t [NUM_SOURCES-1:0][NUM_ELEMENTS-1:0]     in_dat,
  input  logic  [NUM_SOURCES-1:0][NUM_ELEMENTS-1:0]     in_keep,
  input  logic  [NUM_SOURCES-1:0]                       in_last,
  output logic                                          out_vld,
  input  logic                                          out_rdy,
  output data_t [NUM_ELEMENTS-1:0]                      out_dat,
  output logic  [NUM_ELEMENTS-1:0]                      out_keep,
  output logic                                          out_last,
  output logic  [NUM_ELEMENTS-1:0][SERIAL_WIDTH-1:0]    out_tag,
  output logic  [SRC_BITS-1:0]                          out_src,
  output logic                                          busy
);

  arb_state_t              state_q, state_d;
  logic [SRC_BITS-1:0]     rr_ptr, grant, pick;
  logic [SERIAL_WIDTH-1:0] beat_cnt;
  logic                    any_req, slot_free, accept, accept_last;

  rr_pick #(.N(NUM_SOURCES), .W(SRC_BITS)) u_pick (
    .req     (in_vld),
    .ptr     (rr_ptr),
    .gnt     (pick),
    .any_req (any_req)
  );

  assign slot_free   = !out_vld || out_rdy;
  assign accept      = in_vld[grant] && in_rdy[grant];
  assign accept_last = accept && in_last[grant];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (accept_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == BUSY);
    in_rdy = '0;
    if (state_q == BUSY) in_rdy[grant] = slot_free;
  end

  // Pointer only moves on a completed packet, so a reset-aborted packet is never credited.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      out_vld  <= 1'b0;
    end else begin
      if (state_q == IDLE && any_req) grant <= pick;
      if (accept) begin
        if (in_last[grant]) begin
          beat_cnt <= '0;
          rr_ptr   <= (grant == SRC_BITS'(NUM_SOURCES - 1)) ? '0 : grant + SRC_BITS'(1);
        end else begin
          beat_cnt <= beat_cnt + SERIAL_WIDTH'(1);
        end
      end
      if (accept)       out_vld <= 1'b1;
      else if (out_rdy) out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_dat  <= in_dat[grant];
      out_keep <= in_keep[grant];
      out_last <= in_last[grant];
      out_src  <= grant;
      for (int i = 0; i < NUM_ELEMENTS; i++)
        out_tag[i] <= (beat_cnt << ELEMENT_BITS) + SERIAL_WIDTH'(i);
    end
  end

endmodule

// File: tb/tb_tagged_stream_arbiter.sv
// Randomized bench for tagged_stream_arbiter against a packet-level round-robin scoreboard.
// A second small instance exercises serial wrap-around with narrow tags.
module tb_tagged_stream_arbiter;

  localparam int N  = 4;
  localparam int NE = 8;
  localparam int SW = 32;

  typedef logic [7:0] elem_t;
  typedef struct packed {
    logic [NE-1:0][7:0] dat;
    logic [NE-1:0]      keep;
    logic               last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]                 in_vld, in_rdy, in_last;
  elem_t [N-1:0][NE-1:0]        in_dat;
  logic [N-1:0][NE-1:0]         in_keep;
  logic                         out_vld, out_rdy, out_last, busy;
  elem_t [NE-1:0]               out_dat;
  logic [NE-1:0]                out_keep;
  logic [NE-1:0][SW-1:0]        out_tag;
  logic [1:0]                   out_src;

  logic [1:0]                   s_in_vld, s_in_rdy, s_in_last;
  elem_t [1:0][3:0]             s_in_dat;
  logic [1:0][3:0]              s_in_keep;
  logic                         s_out_vld, s_out_rdy, s_out_last, s_busy;
  elem_t [3:0]                  s_out_dat;
  logic [3:0]                   s_out_keep;
  logic [3:0][3:0]              s_out_tag;
  logic                         s_out_src;

  always #5 clk = ~clk;

  tagged_stream_arbiter #(.data_t(elem_t), .NUM_ELEMENTS(NE), .SERIAL_WIDTH(SW), .NUM_SOURCES(N)) u_dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_keep(in_keep), .in_last(in_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_keep(out_keep),
    .out_last(out_last), .out_tag(out_tag), .out_src(out_src), .busy(busy)
  );

  tagged_stream_arbiter #(.data_t(elem_t), .NUM_ELEMENTS(4), .SERIAL_WIDTH(4), .NUM_SOURCES(2)) u_small (
    .clk(clk), .rst(rst),
    .in_vld(s_in_vld), .in_rdy(s_in_rdy), .in_dat(s_in_dat), .in_keep(s_in_keep), .in_last(s_in_last),
    .out_vld(s_out_vld), .out_rdy(s_out_rdy), .out_dat(s_out_dat), .out_keep(s_out_keep),
    .out_last(s_out_last), .out_tag(s_out_tag), .out_src(s_out_src), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: per-source packet lengths and generated beats, plus the expected packet source order.
  int    pkt_q[N][$];
  beat_t sent_q[N][$];
  int    exp_src[$];
  int    beat_idx[N], gap_left[N];
  bit    have_cur[N], fired[N];
  beat_t cur[N];
  int    in_pk, out_pk, out_bidx, model_ptr, gap_max, idle_run, open_src;
  bit    rand_rdy, gap_chk, after_last, prev_stall, pkt_open;
  logic [255:0] snap_f, snap_t;

  task automatic clear_bench();
    for (int s = 0; s < N; s++) begin
      pkt_q[s].delete();
      sent_q[s].delete();
      beat_idx[s] = 0; gap_left[s] = 0; have_cur[s] = 0; fired[s] = 0;
    end
    exp_src.delete();
    in_pk = 0; out_pk = 0; out_bidx = 0; idle_run = 0;
    prev_stall = 0; pkt_open = 0; after_last = 0;
    in_vld = '0; in_last = '0; in_dat = '0; in_keep = '0; out_rdy = 1'b1;
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      if (fired[s]) begin
        have_cur[s] = 0;
        if (cur[s].last) begin
          void'(pkt_q[s].pop_front());
          beat_idx[s] = 0;
        end else begin
          beat_idx[s]++;
          if (gap_max > 0 && $urandom_range(0, 2) == 0) gap_left[s] = $urandom_range(1, gap_max);
        end
        fired[s] = 0;
      end
      if (!have_cur[s] && pkt_q[s].size() > 0) begin
        cur[s].dat  = {$urandom, $urandom};
        cur[s].keep = 8'($urandom);
        cur[s].last = (beat_idx[s] == pkt_q[s][0] - 1);
        sent_q[s].push_back(cur[s]);
        have_cur[s] = 1;
      end
      if (gap_left[s] > 0) begin
        in_vld[s] = 1'b0;
        gap_left[s]--;
      end else begin
        in_vld[s] = have_cur[s];
      end
      in_dat[s]  = cur[s].dat;
      in_keep[s] = cur[s].keep;
      in_last[s] = cur[s].last;
    end
    out_rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic sample();
    int                    es;
    beat_t                 eb;
    logic [NE-1:0][SW-1:0] et;
    if (pkt_open) check("rdy_owner", in_rdy[open_src], !(out_vld && !out_rdy));
    check("rdy_onehot", $onehot0(in_rdy), 1);
    check("rdy_when_full", (|in_rdy) && out_vld && !out_rdy, 0);
    for (int s = 0; s < N; s++) begin
      fired[s] = in_vld[s] && in_rdy[s];
      if (fired[s]) begin
        check("grant_src", s, (in_pk < exp_src.size()) ? exp_src[in_pk] : -1);
        if (cur[s].last) begin
          in_pk++;
          pkt_open = 0;
        end else begin
          pkt_open = 1;
          open_src = s;
        end
      end
    end
    if (prev_stall) begin
      check("hold_vld", out_vld, 1);
      check("hold_fields", {out_dat, out_keep, out_last, out_src}, snap_f);
      check("hold_tag", out_tag, snap_t);
    end
    prev_stall = out_vld && !out_rdy;
    snap_f = {out_dat, out_keep, out_last, out_src};
    snap_t = out_tag;
    if (out_vld && out_rdy) begin
      es = (out_pk < exp_src.size()) ? exp_src[out_pk] : 0;
      check("out_src", out_src, es);
      if (sent_q[es].size() == 0) begin
        check("out_extra_beat", 1, 0);
      end else begin
        eb = sent_q[es].pop_front();
        check("out_dat", out_dat, eb.dat);
        check("out_keep", out_keep, eb.keep);
        check("out_last", out_last, eb.last);
      end
      for (int i = 0; i < NE; i++) et[i] = SW'(out_bidx * NE + i);
      check("out_tag", out_tag, et);
      if (out_last) begin
        out_pk++;
        out_bidx = 0;
      end else begin
        out_bidx++;
      end
    end
    if (out_vld) begin
      if (gap_chk && after_last) check("bubble", idle_run, 1);
      after_last = out_last;
      idle_run = 0;
    end else begin
      idle_run++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n = 0;
    while (!(out_pk == exp_src.size() && in_pk == exp_src.size()) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, n < budget, 1);
    repeat (3) cycle();
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_vld_after"}, out_vld, 0);
  endtask

  // Every source always has its next packet ready, so the order is a plain rotation from the pointer.
  task automatic rotation(input int per_src, input int minlen, input int maxlen);
    int s;
    for (int k = 0; k < N * per_src; k++) begin
      s = (model_ptr + k) % N;
      exp_src.push_back(s);
      pkt_q[s].push_back($urandom_range(minlen, maxlen));
    end
    model_ptr = (exp_src[$] + 1) % N;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_bench();
    check("rst_out_vld", out_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_in_rdy", in_rdy, 0);
    model_ptr = 0;
  endtask

  initial begin
    int n, got, sbeat, spkt, obidx;
    int lens[2];
    logic [3:0][3:0] st;
    clear_bench();
    s_in_vld = '0; s_in_last = '0; s_in_dat = '0; s_in_keep = '0; s_out_rdy = 1'b1;
    gap_max = 0; rand_rdy = 0; gap_chk = 0; model_ptr = 0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_vld", out_vld, 0);
    check("reset_busy", busy, 0);
    check("reset_in_rdy", in_rdy, 0);
    check("reset_small_vld", s_out_vld, 0);
    rst = 1'b0;

    // Single 3-beat packet from source 0.
    exp_src.push_back(0);
    pkt_q[0].push_back(3);
    model_ptr = 1;
    drive();
    run_until_drained("single_src", 50);

    // All sources streaming 2-beat packets, output always ready.
    gap_chk = 1;
    after_last = 0;
    rotation(3, 2, 2);
    drive();
    run_until_drained("rr_all", 400);
    gap_chk = 0;

    // Random lengths, random output stalls, mid-packet valid gaps.
    rand_rdy = 1;
    gap_max = 10;
    rotation(4, 1, 5);
    drive();
    run_until_drained("random", 4000);
    rand_rdy = 0;
    gap_max = 0;

    // Abort a packet of source 2 by reset, then check arbitration restarts at index 0.
    reset_pulse();
    exp_src = '{0, 1, 2};
    pkt_q[0].push_back(1);
    pkt_q[1].push_back(1);
    pkt_q[2].push_back(30);
    drive();
    n = 0;
    while (!(out_pk == 2 && out_bidx >= 3) && n < 200) begin
      cycle();
      n++;
    end
    check("abort_reached", n < 200, 1);
    check("abort_out_vld_before", out_vld, 1);
    reset_pulse();
    exp_src = '{1, 3};
    pkt_q[1].push_back(1);
    pkt_q[3].push_back(1);
    drive();
    run_until_drained("post_reset", 50);

    // Narrow serials: 4 elements, 4-bit tags, 5-beat packet then single-beat packet.
    lens = '{5, 1};
    got = 0; sbeat = 0; spkt = 0; obidx = 0; n = 0;
    while (got < 6 && n < 80) begin
      s_in_vld[0]  = (spkt < 2);
      s_in_last[0] = (spkt < 2) && (sbeat == lens[spkt < 2 ? spkt : 0] - 1);
      @(negedge clk);
      if (s_in_vld[0] && s_in_rdy[0]) begin
        if (s_in_last[0]) begin
          spkt++;
          sbeat = 0;
        end else begin
          sbeat++;
        end
      end
      if (s_out_vld) begin
        for (int i = 0; i < 4; i++) st[i] = 4'(obidx * 4 + i);
        check("wrap_tag", s_out_tag, st);
        check("wrap_src", s_out_src, 0);
        if (s_out_last) obidx = 0;
        else            obidx++;
        got++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("wrap_beats", got, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
